// File: rtl/seq_pkg.sv
// Shared constants for the serializer and the downstream sequence detector bench.
package seq_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam logic        DEF_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/seq_serializer_if.sv
// Load handshake and serial output bundle of seq_serializer.
interface seq_serializer_if #(
  parameter int unsigned WIDTH = seq_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] DATA_IN;
  logic             LOAD_VALID;
  logic             LOAD_READY;
  logic             SER_OUT;
  logic             SER_VALID;
  logic             FRAME_DONE;
  logic             BUSY;

  modport master (
    output DATA_IN, LOAD_VALID,
    input  LOAD_READY, SER_OUT, SER_VALID, FRAME_DONE, BUSY
  );

  modport slave (
    input  DATA_IN, LOAD_VALID,
    output LOAD_READY, SER_OUT, SER_VALID, FRAME_DONE, BUSY
  );
endinterface

// File: rtl/seq_serializer.sv
// MSB-first parallel-to-serial stage feeding the sequence detector, gap-free back-to-back.
// Optional trailing even-parity bit when SERIAL_PARITY_EN is defined.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter logic        IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input logic             CLK,
  input logic             RESET,
  seq_serializer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             load_ready_c;
  logic             accept_c;
`ifdef SERIAL_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Ready window: idle, or the final bit of the frame is on the line.
  always_comb begin
    load_ready_c = 1'b0;
    if (state_q == ST_IDLE) begin
      load_ready_c = 1'b1;
    end
`ifdef SERIAL_PARITY_EN
    else if (state_q == ST_PARITY) begin
      load_ready_c = 1'b1;
    end
`else
    else if (state_q == ST_SHIFT && cnt_q == '0) begin
      load_ready_c = 1'b1;
    end
`endif
  end

  assign accept_c = bus.LOAD_VALID && load_ready_c;

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    ser_out_d    = IDLE_LEVEL;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;
`ifdef SERIAL_PARITY_EN
    parity_d     = parity_q;
`endif

    case (state_q)
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          sreg_d      = sreg_q << 1;
          ser_out_d   = sreg_q[WIDTH-2];
          ser_valid_d = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
`ifndef SERIAL_PARITY_EN
          frame_done_d = (cnt_q == CNT_W'(1));
`endif
        end else begin
`ifdef SERIAL_PARITY_EN
          state_d      = ST_PARITY;
          ser_out_d    = parity_q;
          ser_valid_d  = 1'b1;
          frame_done_d = 1'b1;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      ST_PARITY: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase

    // A load overrides the end-of-frame return to idle, giving zero-gap frames.
    if (accept_c) begin
      state_d      = ST_SHIFT;
      sreg_d       = bus.DATA_IN;
      cnt_d        = CNT_W'(WIDTH - 1);
      ser_out_d    = bus.DATA_IN[WIDTH-1];
      ser_valid_d  = 1'b1;
      frame_done_d = 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_d     = ^bus.DATA_IN;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      ser_out_q    <= IDLE_LEVEL;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
`ifdef SERIAL_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.LOAD_READY = load_ready_c;
  assign bus.SER_OUT    = ser_out_q;
  assign bus.SER_VALID  = ser_valid_q;
  assign bus.FRAME_DONE = frame_done_q;
  assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: directed plan words plus random traffic
// against an expected-bit-stream model; honours SERIAL_PARITY_EN.
module tb_seq_serializer;
  import seq_pkg::*;

  localparam int unsigned W = DEF_WIDTH;

  logic CLK = 1'b0;
  logic RESET;

  seq_serializer_if #(.WIDTH(W)) bus ();

  seq_serializer #(
    .WIDTH      (W),
    .IDLE_LEVEL (DEF_IDLE_LEVEL)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  bit           exp_q[$];
  logic [W-1:0] pend_q[$];
  bit           gaps = 1'b0;
  int           done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upstream driver: hold a presented word until accepted, otherwise maybe present the next one.
  task automatic drive_next();
    if (!bus.LOAD_VALID) begin
      if (pend_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        bus.LOAD_VALID = 1'b1;
        bus.DATA_IN    = pend_q[0];
      end else begin
        bus.DATA_IN = W'($urandom);
      end
    end
  endtask

  // One clock: predict, advance, compare, then update upstream stimulus.
  task automatic step();
    logic         m_ready;
    logic         acc;
    logic [W-1:0] word;
    logic         e_out, e_val, e_done, e_busy;
    m_ready = (exp_q.size() == 0);
    acc     = bus.LOAD_VALID && m_ready && !RESET;
    word    = bus.DATA_IN;
    check("load_ready", 32'(bus.LOAD_READY), 32'(m_ready));
    @(posedge CLK);
    if (RESET) begin
      exp_q.delete();
    end else if (acc) begin
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(word[i]);
`ifdef SERIAL_PARITY_EN
      exp_q.push_back(^word);
`endif
      void'(pend_q.pop_front());
    end
    if (exp_q.size() > 0) begin
      e_out  = exp_q.pop_front();
      e_val  = 1'b1;
      e_done = (exp_q.size() == 0);
      e_busy = 1'b1;
    end else begin
      e_out  = DEF_IDLE_LEVEL;
      e_val  = 1'b0;
      e_done = 1'b0;
      e_busy = 1'b0;
    end
    #1;
    check("ser_out",    32'(bus.SER_OUT),    32'(e_out));
    check("ser_valid",  32'(bus.SER_VALID),  32'(e_val));
    check("frame_done", 32'(bus.FRAME_DONE), 32'(e_done));
    check("busy",       32'(bus.BUSY),       32'(e_busy));
    if (bus.FRAME_DONE) done_cnt++;
    if (acc) bus.LOAD_VALID = 1'b0;
    drive_next();
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic push_word(input logic [W-1:0] w);
    pend_q.push_back(w);
    drive_next();
  endtask

  int done_before;

  initial begin
    RESET          = 1'b1;
    bus.LOAD_VALID = 1'b1;
    bus.DATA_IN    = 8'h77;
    #1;
    check("rst_ser_out",    32'(bus.SER_OUT),    32'(DEF_IDLE_LEVEL));
    check("rst_ser_valid",  32'(bus.SER_VALID),  32'd0);
    check("rst_load_ready", 32'(bus.LOAD_READY), 32'd1);
    check("rst_busy",       32'(bus.BUSY),       32'd0);
    check("rst_frame_done", 32'(bus.FRAME_DONE), 32'd0);
    // Valid load held during reset must not be captured.
    run(3);
    RESET          = 1'b0;
    bus.LOAD_VALID = 1'b0;
    run(2);

    // Single word: 0,1,1,1,0,1,1,1 then idle.
    done_before = done_cnt;
    push_word(8'h77);
    run(12);
    check("single_done_pulses", 32'(done_cnt - done_before), 32'd1);

    // Back-to-back with valid held.
    done_before = done_cnt;
    push_word(8'hA5);
    push_word(8'h3C);
    run(22);
    check("b2b_done_pulses", 32'(done_cnt - done_before), 32'd2);

    // Second word is presented while blocked, then follows immediately.
    push_word(8'hF0);
    push_word(8'h0F);
    run(22);

    // Reset after three bits of 8'hC3.
    push_word(8'hC3);
    for (int c = 0; c < 20 && pend_q.size() > 0; c++) step();
    check("c3_accepted", 32'(pend_q.size()), 32'd0);
    run(2);
    RESET = 1'b1;
    #1;
    check("midrst_ser_valid", 32'(bus.SER_VALID), 32'd0);
    check("midrst_ser_out",   32'(bus.SER_OUT),   32'(DEF_IDLE_LEVEL));
    check("midrst_busy",      32'(bus.BUSY),      32'd0);
    check("midrst_ready",     32'(bus.LOAD_READY), 32'd1);
    exp_q.delete();
    #1;
    RESET = 1'b0;
    push_word(8'h01);
    run(12);

    // Parity words (frame lengths differ only under SERIAL_PARITY_EN).
    push_word(8'h07);
    push_word(8'h03);
    run(24);

    // Random traffic with random upstream gaps.
    gaps = 1'b1;
    for (int n = 0; n < 200; n++) begin
      push_word(W'($urandom));
      run($urandom_range(1, 12));
    end
    run(3 * W * (pend_q.size() + 2));
    check("random_drained", 32'(pend_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
